// File: rtl/tp_mem_sched_pkg.sv
// Shared types and constants for the two-port memory access scheduler.
package tp_mem_sched_pkg;

    // Scheduler FSM states: zero-fill, normal arbitration, waiting on a
    // CBUS read, and the one-cycle turnaround after every CBUS access.
    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_RDPEND = 2'd2,
        S_GAP    = 2'd3
    } sched_state_e;

    // CBUS read data is always presented at this width, zero-extended.
    localparam int CBUS_DW = 32;

    // Encoding of cbus_cmd.
    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

endpackage

// File: rtl/tp_rd_lat_pipe.sv
// Valid-only delay line: flags the cycle in which memory read data
// requested LAT cycles earlier is present on the memory read data bus.
module tp_rd_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic valid_o
);

    logic [LAT-1:0] shift_q;

    // Shift the issue flag along one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q[0] <= valid_i;
            for (int i = 1; i < LAT; i++) begin
                shift_q[i] <= shift_q[i-1];
            end
        end
    end

    assign valid_o = shift_q[LAT-1];

endmodule

// File: rtl/tp_mem_access_sched.sv
// Shares one 1W/1R memory between a PHY requester (priority) and a CBUS
// slave, with a starvation counter that eventually forces a CBUS slot,
// and a zero-fill sequence over the whole array.
module tp_mem_access_sched
    import tp_mem_sched_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 8,
    parameter int RD_LAT      = 1,
    parameter int STARVE_MAX  = 15,
    parameter bit INIT_ON_RST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_start_i,
    output logic               init_busy_o,
    output logic               init_done_o,
    input  logic               cbus_req_i,
    input  logic               cbus_cmd_i,
    input  logic [AW-1:0]      cbus_addr_i,
    input  logic [DW-1:0]      cbus_wrdata_i,
    output logic               cbus_waccept_o,
    output logic               cbus_rresp_o,
    output logic [CBUS_DW-1:0] cbus_rddata_o,
    input  logic [AW-1:0]      phy_wr_addr_i,
    input  logic [DW-1:0]      phy_wr_data_i,
    input  logic [DW-1:0]      phy_wr_mask_i,
    input  logic               phy_wr_me_en_i,
    input  logic [AW-1:0]      phy_rd_addr_i,
    input  logic               phy_rd_me_en_i,
    output logic               phy_wr_stall_o,
    output logic               phy_rd_stall_o,
    output logic [AW-1:0]      mem_wr_addr_o,
    output logic [DW-1:0]      mem_wr_data_o,
    output logic [DW-1:0]      mem_wr_mask_o,
    output logic               mem_wr_me_en_o,
    output logic [AW-1:0]      mem_rd_addr_o,
    output logic               mem_rd_me_en_o,
    input  logic [DW-1:0]      mem_rd_data_i
);

    localparam logic [7:0]    STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [AW-1:0] LAST_ADDR  = '1;
    localparam sched_state_e  RST_STATE  = INIT_ON_RST ? S_INIT : S_RUN;

    sched_state_e        state_q, state_d;
    logic [AW-1:0]       fillAddr_q, fillAddr_d;
    logic [7:0]          starveCnt_q, starveCnt_d;
    logic                initDone_q, initDone_d;
    logic                initPend_q, initPend_d;
    logic                rresp_q;
    logic [CBUS_DW-1:0]  rddata_q;

    logic                cbusWrReq, cbusRdReq;
    logic                rdGrant, rdValid;
    logic                initBusy, waccept, phyWrStall, phyRdStall;
    logic [AW-1:0]       memWrAddr, memRdAddr;
    logic [DW-1:0]       memWrData, memWrMask;
    logic                memWrEn, memRdEn;

    assign cbusWrReq = cbus_req_i && (cbus_cmd_i == CMD_WR);
    assign cbusRdReq = cbus_req_i && (cbus_cmd_i == CMD_RD);

    tp_rd_lat_pipe #(
        .LAT     (RD_LAT)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rdGrant),
        .valid_o (rdValid)
    );

    // State, fill pointer, starvation counter and init bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            fillAddr_q  <= '0;
            starveCnt_q <= '0;
            initDone_q  <= 1'b0;
            initPend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fillAddr_q  <= fillAddr_d;
            starveCnt_q <= starveCnt_d;
            initDone_q  <= initDone_d;
            initPend_q  <= initPend_d;
        end
    end

    // Next-state logic plus per-port arbitration; PHY traffic passes through unless CBUS wins.
    always_comb begin
        state_d     = state_q;
        fillAddr_d  = '0;
        starveCnt_d = starveCnt_q;
        initDone_d  = initDone_q;
        initPend_d  = initPend_q;
        memWrAddr   = phy_wr_addr_i;
        memWrData   = phy_wr_data_i;
        memWrMask   = phy_wr_mask_i;
        memWrEn     = phy_wr_me_en_i;
        memRdAddr   = phy_rd_addr_i;
        memRdEn     = phy_rd_me_en_i;
        phyWrStall  = 1'b0;
        phyRdStall  = 1'b0;
        waccept     = 1'b0;
        rdGrant     = 1'b0;
        initBusy    = 1'b0;

        if (!cbus_req_i) begin
            starveCnt_d = '0;
        end

        case (state_q)
            S_INIT: begin
                initBusy   = 1'b1;
                memWrAddr  = fillAddr_q;
                memWrData  = '0;
                memWrMask  = '1;
                memWrEn    = 1'b1;
                phyWrStall = 1'b1;
                fillAddr_d = fillAddr_q + AW'(1);
                if (fillAddr_q == LAST_ADDR) begin
                    state_d    = S_RUN;
                    initDone_d = 1'b1;
                end
            end
            S_RUN: begin
                if (init_start_i) begin
                    state_d    = S_INIT;
                    initDone_d = 1'b0;
                end else if (cbusWrReq) begin
                    if (!phy_wr_me_en_i || (starveCnt_q == STARVE_LIM)) begin
                        memWrAddr   = cbus_addr_i;
                        memWrData   = cbus_wrdata_i;
                        memWrMask   = '1;
                        memWrEn     = 1'b1;
                        phyWrStall  = phy_wr_me_en_i;
                        waccept     = 1'b1;
                        starveCnt_d = '0;
                        state_d     = S_GAP;
                    end else begin
                        starveCnt_d = starveCnt_q + 8'd1;
                    end
                end else if (cbusRdReq) begin
                    if (!phy_rd_me_en_i || (starveCnt_q == STARVE_LIM)) begin
                        memRdAddr   = cbus_addr_i;
                        memRdEn     = 1'b1;
                        phyRdStall  = phy_rd_me_en_i;
                        rdGrant     = 1'b1;
                        starveCnt_d = '0;
                        state_d     = S_RDPEND;
                    end else begin
                        starveCnt_d = starveCnt_q + 8'd1;
                    end
                end
            end
            S_RDPEND: begin
                if (init_start_i) begin
                    initPend_d = 1'b1;
                end
                if (rdValid) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (init_start_i || initPend_q) begin
                    state_d    = S_INIT;
                    initDone_d = 1'b0;
                    initPend_d = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // Register the CBUS read response one cycle after the memory data is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rresp_q  <= 1'b0;
            rddata_q <= '0;
        end else begin
            rresp_q  <= rdValid;
            rddata_q <= rdValid ? CBUS_DW'(mem_rd_data_i) : '0;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign init_busy_o    = rst ? 1'b0 : initBusy;
    assign cbus_waccept_o = rst ? 1'b0 : waccept;
    assign phy_wr_stall_o = rst ? 1'b0 : phyWrStall;
    assign phy_rd_stall_o = rst ? 1'b0 : phyRdStall;
    assign mem_wr_addr_o  = rst ? '0   : memWrAddr;
    assign mem_wr_data_o  = rst ? '0   : memWrData;
    assign mem_wr_mask_o  = rst ? '0   : memWrMask;
    assign mem_wr_me_en_o = rst ? 1'b0 : memWrEn;
    assign mem_rd_addr_o  = rst ? '0   : memRdAddr;
    assign mem_rd_me_en_o = rst ? 1'b0 : memRdEn;
    assign init_done_o    = initDone_q;
    assign cbus_rresp_o   = rresp_q;
    assign cbus_rddata_o  = rddata_q;

endmodule

// File: tb/tb_tp_mem_access_sched.sv
// Scoreboard bench for tp_mem_access_sched with a behavioural two-port memory.
module tb_tp_mem_access_sched;

    localparam int DW         = 8;
    localparam int AW         = 5;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 3;
    localparam int DEPTH      = 32;

    logic          clk;
    logic          rst;
    logic          init_start, init_busy, init_done;
    logic          cbus_req, cbus_cmd;
    logic [AW-1:0] cbus_addr;
    logic [DW-1:0] cbus_wrdata;
    logic          cbus_waccept, cbus_rresp;
    logic [31:0]   cbus_rddata;
    logic [AW-1:0] phy_wr_addr, phy_rd_addr;
    logic [DW-1:0] phy_wr_data, phy_wr_mask;
    logic          phy_wr_me_en, phy_rd_me_en;
    logic          phy_wr_stall, phy_rd_stall;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data, mem_wr_mask, mem_rd_data;
    logic          mem_wr_me_en, mem_rd_me_en;

    int cyc = 0;
    int checksDone = 0;
    int checksPassed = 0;
    int wrSeen = 0;
    int rdSeen = 0;
    int idleViol = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t expWrQ[$];
    exp_t expRdQ[$];
    exp_t monWr, monRd;

    logic [DW-1:0] memArr [DEPTH];
    logic [DW-1:0] rdPipe [RD_LAT];

    tp_mem_access_sched #(
        .DW          (DW),
        .AW          (AW),
        .RD_LAT      (RD_LAT),
        .STARVE_MAX  (STARVE_MAX),
        .INIT_ON_RST (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .init_start_i   (init_start),
        .init_busy_o    (init_busy),
        .init_done_o    (init_done),
        .cbus_req_i     (cbus_req),
        .cbus_cmd_i     (cbus_cmd),
        .cbus_addr_i    (cbus_addr),
        .cbus_wrdata_i  (cbus_wrdata),
        .cbus_waccept_o (cbus_waccept),
        .cbus_rresp_o   (cbus_rresp),
        .cbus_rddata_o  (cbus_rddata),
        .phy_wr_addr_i  (phy_wr_addr),
        .phy_wr_data_i  (phy_wr_data),
        .phy_wr_mask_i  (phy_wr_mask),
        .phy_wr_me_en_i (phy_wr_me_en),
        .phy_rd_addr_i  (phy_rd_addr),
        .phy_rd_me_en_i (phy_rd_me_en),
        .phy_wr_stall_o (phy_wr_stall),
        .phy_rd_stall_o (phy_rd_stall),
        .mem_wr_addr_o  (mem_wr_addr),
        .mem_wr_data_o  (mem_wr_data),
        .mem_wr_mask_o  (mem_wr_mask),
        .mem_wr_me_en_o (mem_wr_me_en),
        .mem_rd_addr_o  (mem_rd_addr),
        .mem_rd_me_en_o (mem_rd_me_en),
        .mem_rd_data_i  (mem_rd_data)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index; cycle k runs from the k-th rising edge to the next one.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Behavioural two-port memory with masked writes and RD_LAT read latency.
    always @(posedge clk) begin
        if (mem_wr_me_en) begin
            memArr[mem_wr_addr] <= (memArr[mem_wr_addr] & ~mem_wr_mask) | (mem_wr_data & mem_wr_mask);
        end
        rdPipe[0] <= mem_rd_me_en ? memArr[mem_rd_addr] : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            rdPipe[i] <= rdPipe[i-1];
        end
    end

    assign mem_rd_data = rdPipe[RD_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksDone++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checksDone++;
        $display("[TB] FAIL %s: timed out waiting for DUT response", name);
    endtask

    task automatic applyStimulus(input logic req, input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        @(posedge clk);
        #1;
        cbus_req    = req;
        cbus_cmd    = cmd;
        cbus_addr   = addr;
        cbus_wrdata = wd;
    endtask

    task automatic waitWr(input string name, input int prev);
        int budget;
        budget = 30;
        while (wrSeen == prev && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (wrSeen == prev) timeoutFail(name);
    endtask

    task automatic waitRd(input string name, input int prev);
        int budget;
        budget = 30;
        while (rdSeen == prev && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (rdSeen == prev) timeoutFail(name);
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents a write accept or read response.
    always @(negedge clk) begin
        if (cbus_waccept) begin
            wrSeen++;
            if (expWrQ.size() == 0) begin
                checksDone++;
                $display("[TB] FAIL unexpected waccept: got pulse at cycle %0d, expected none", cyc);
            end else begin
                monWr = expWrQ.pop_front();
                checkOutput("waccept cycle", 32'(cyc), 32'(monWr.cyc));
                checkOutput("cbus write addr/en/mask", {16'(mem_wr_addr), 7'd0, mem_wr_me_en, mem_wr_mask},
                            {monWr.addr[15:0], 7'd0, 1'b1, 8'hFF});
                checkOutput("cbus write data", 32'(mem_wr_data), monWr.data);
            end
        end
        if (cbus_rresp) begin
            rdSeen++;
            if (expRdQ.size() == 0) begin
                checksDone++;
                $display("[TB] FAIL unexpected rresp: got pulse at cycle %0d, expected none", cyc);
            end else begin
                monRd = expRdQ.pop_front();
                checkOutput("rresp cycle", 32'(cyc), 32'(monRd.cyc));
                checkOutput("rresp data", cbus_rddata, monRd.data);
            end
        end else if (cbus_rddata != 32'd0) begin
            idleViol++;
        end
    end

    // Fail-safe so the run always ends even if the stimulus gets stuck.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenario sequence.
    initial begin
        rst          = 1'b1;
        init_start   = 1'b0;
        cbus_req     = 1'b0;
        cbus_cmd     = 1'b0;
        cbus_addr    = '0;
        cbus_wrdata  = '0;
        phy_wr_addr  = '0;
        phy_wr_data  = '0;
        phy_wr_mask  = 8'hFF;
        phy_wr_me_en = 1'b1;
        phy_rd_addr  = 5'd3;
        phy_rd_me_en = 1'b1;

        // Reset: everything low even with the PHY requesting.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset flags", {24'd0, init_busy, init_done, mem_wr_me_en, mem_rd_me_en,
                                    phy_wr_stall, phy_rd_stall, cbus_waccept, cbus_rresp}, 32'd0);
        checkOutput("reset buses", {8'(mem_wr_addr), mem_wr_mask, 8'(mem_rd_addr), mem_wr_data}, 32'd0);

        // Zero-fill after release: one address per cycle, PHY writes stalled, PHY reads passing.
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("fill addr %0d", i), 32'(mem_wr_addr), 32'(i));
            checkOutput($sformatf("fill ctl %0d", i), {13'd0, init_busy, mem_wr_me_en, phy_wr_stall, mem_wr_mask, mem_wr_data},
                        {13'd0, 3'b111, 8'hFF, 8'h00});
            if (i == 5) begin
                checkOutput("phy read during fill", {26'd0, mem_rd_me_en, mem_rd_addr}, 32'h0000_0023);
            end
        end
        @(negedge clk);
        #1;
        checkOutput("fill complete", {29'd0, init_busy, init_done, phy_wr_stall}, 32'h0000_0002);

        // CBUS write with PHY idle: accepted in the same cycle it is requested.
        applyStimulus(1'b1, 1'b1, 5'h12, 8'hA5);
        phy_wr_me_en = 1'b0;
        phy_rd_me_en = 1'b0;
        expWrQ.push_back('{cyc, 32'h12, 32'hA5});
        waitWr("write 0x12", 0);

        // Second write held through the turnaround cycle: granted two cycles after the first.
        applyStimulus(1'b1, 1'b1, 5'h13, 8'h5A);
        expWrQ.push_back('{cyc + 1, 32'h13, 32'h5A});
        @(negedge clk);
        #1;
        checkOutput("turnaround no grant", {30'd0, cbus_waccept, mem_wr_me_en}, 32'd0);
        waitWr("write 0x13", 1);

        // CBUS read of 0x12: granted next cycle, response RD_LAT+1 cycles after grant.
        applyStimulus(1'b1, 1'b0, 5'h12, 8'h00);
        expRdQ.push_back('{cyc + 4, 32'h12, 32'h0000_00A5});
        waitRd("read 0x12", 0);

        // Starvation: PHY read held, CBUS read wins on the fourth contended cycle.
        applyStimulus(1'b1, 1'b0, 5'h13, 8'h00);
        phy_rd_me_en = 1'b1;
        phy_rd_addr  = 5'd7;
        expRdQ.push_back('{cyc + 6, 32'h13, 32'h0000_005A});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("starve rd stall %0d", k), 32'(phy_rd_stall), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) begin
                checkOutput("starve cbus rd grant", {26'd0, mem_rd_me_en, mem_rd_addr}, 32'h0000_0033);
            end else if (k < 3) begin
                checkOutput($sformatf("starve phy rd %0d", k), {26'd0, mem_rd_me_en, mem_rd_addr}, 32'h0000_0027);
            end
        end
        waitRd("read 0x13", 1);

        // CBUS write alongside a continuous PHY read: separate ports, no stall.
        applyStimulus(1'b1, 1'b1, 5'h05, 8'h3C);
        expWrQ.push_back('{cyc, 32'h05, 32'h3C});
        @(negedge clk);
        #1;
        checkOutput("write vs phy read", {29'd0, phy_rd_stall, phy_wr_stall, mem_rd_me_en}, 32'h0000_0001);
        waitWr("write 0x05", 2);

        // Reset while a CBUS read is pending: response dropped, fill restarts at 0.
        applyStimulus(1'b1, 1'b0, 5'h05, 8'h00);
        phy_rd_me_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("pending read grant", {26'd0, mem_rd_me_en, mem_rd_addr}, 32'h0000_0025);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        cbus_req = 1'b0;
        #1;
        checkOutput("async reset flags", {24'd0, init_busy, init_done, mem_wr_me_en, mem_rd_me_en,
                                          phy_wr_stall, phy_rd_stall, cbus_waccept, cbus_rresp}, 32'd0);
        checkOutput("async reset rd addr", 32'(mem_rd_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("refill addr 0", {26'd0, init_busy, mem_wr_addr}, 32'h0000_0020);
        @(negedge clk);
        #1;
        checkOutput("refill addr 1", {26'd0, init_busy, mem_wr_addr}, 32'h0000_0021);
        begin
            int budget;
            budget = 40;
            while (!init_done && budget > 0) begin
                @(negedge clk);
                #1;
                budget--;
            end
            if (!init_done) timeoutFail("refill done");
        end
        checkOutput("refill done flags", {30'd0, init_busy, init_done}, 32'h0000_0001);
        repeat (5) @(negedge clk);
        #1;

        checkOutput("write queue drained", 32'(expWrQ.size()), 32'd0);
        checkOutput("read queue drained", 32'(expRdQ.size()), 32'd0);
        checkOutput("write accept count", 32'(wrSeen), 32'd3);
        checkOutput("read response count", 32'(rdSeen), 32'd2);
        checkOutput("rddata zero when idle", 32'(idleViol), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
